dircc_processing_mem_port_arbiter: RTL

- Shares the 16-bit secondary port (s2) of a node's processing memory between two Avalon-MM masters: m0 is the mailbox receive DMA, m1 is the mailbox send DMA.
- Round-robin arbitration with a bounded grant-hold window.
- Addresses at or above NUM_WORDS are trapped and never reach the RAM.
- Sits between the two DMA engines and the memory's s2 address/byteenable/writedata/chipselect/clken/write pins.

---
 rtl/dircc_processing_mem_port_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dircc_processing_mem_port_arbiter.sv
// Two-master round-robin arbiter for the 16-bit secondary port of the node
// processing memory. m0 = mailbox receive DMA, m1 = mailbox send DMA.
// Out-of-range addresses are trapped before the RAM and answered with SLVERR.
module dircc_processing_mem_port_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 16,
  parameter int BE_W      = 2,
  parameter int NUM_WORDS = 10000,
  parameter int MAX_HOLD  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              freeze,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  output logic [1:0]        m0_response,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [1:0]        m1_response,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [7:0]        err_count,
  output logic              proto_err
);

  localparam logic [3:0]    HOLD_MAX = 4'(MAX_HOLD);
  localparam logic [ADDR_W:0] LIMIT  = (ADDR_W+1)'(NUM_WORDS);

  logic              req0, req1, gnt0, gnt1, acc, gid, hold;
  logic              sel_read, sel_write, in_range;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wd, rdata_val;

  logic              lg_q, lg_d;
  logic [3:0]        hc_q, hc_d;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wd_q;
  logic              rv_q, rid_q, roor_q;
  logic [DATA_W-1:0] rd0_q, rd1_q;
  logic [7:0]        err_q;
  logic              proto_q;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  // hc == 0 means the last cycle was idle, so no master is holding the port
  assign hold = (hc_q != 4'd0) && (hc_q < HOLD_MAX);

  // Grant selection: single requester wins, otherwise hold or rotate
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset && !freeze) begin
      if (req0 && !req1)      gnt0 = 1'b1;
      else if (req1 && !req0) gnt1 = 1'b1;
      else if (req0 && req1) begin
        if (hold == lg_q) gnt1 = 1'b1;
        else              gnt0 = 1'b1;
      end
    end
  end

  assign acc       = gnt0 | gnt1;
  assign gid       = gnt1;
  assign sel_addr  = gid ? m1_address    : m0_address;
  assign sel_read  = gid ? m1_read       : m0_read;
  assign sel_write = gid ? m1_write      : m0_write;
  assign sel_be    = gid ? m1_byteenable : m0_byteenable;
  assign sel_wd    = gid ? m1_writedata  : m0_writedata;
  assign in_range  = {1'b0, sel_addr} < LIMIT;

  assign m0_waitrequest = reset | freeze | (req0 & ~gnt0);
  assign m1_waitrequest = reset | freeze | (req1 & ~gnt1);

  assign mem_address    = acc ? sel_addr : addr_q;
  assign mem_byteenable = acc ? sel_be   : be_q;
  assign mem_writedata  = acc ? sel_wd   : wd_q;
  assign mem_chipselect = acc & in_range;
  assign mem_write      = mem_chipselect & sel_write;
  assign mem_clken      = ~freeze;

  // Read return path: valid one cycle after acceptance, suppressed by reset
  assign m0_readdatavalid = rv_q & ~reset & ~rid_q;
  assign m1_readdatavalid = rv_q & ~reset &  rid_q;
  assign rdata_val   = roor_q ? '0 : mem_readdata;
  assign m0_readdata = m0_readdatavalid ? rdata_val : rd0_q;
  assign m1_readdata = m1_readdatavalid ? rdata_val : rd1_q;
  assign m0_response = (m0_readdatavalid & roor_q) ? 2'b10 : 2'b00;
  assign m1_response = (m1_readdatavalid & roor_q) ? 2'b10 : 2'b00;
  assign err_count   = err_q;
  assign proto_err   = proto_q;

  // Last-grant pointer and hold counter next state
  always_comb begin
    lg_d = lg_q;
    hc_d = 4'd0;
    if (acc) begin
      if (gid == lg_q) begin
        hc_d = (hc_q == 4'd15) ? 4'd15 : hc_q + 4'd1;
      end else begin
        lg_d = gid;
        hc_d = 4'd1;
      end
    end
  end

  // Arbitration state, held command fields, read tracking and error status
  always_ff @(posedge clk) begin
    if (reset) begin
      lg_q    <= 1'b1;
      hc_q    <= 4'd0;
      addr_q  <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      rv_q    <= 1'b0;
      rid_q   <= 1'b0;
      roor_q  <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      err_q   <= 8'd0;
      proto_q <= 1'b0;
    end else begin
      lg_q   <= lg_d;
      hc_q   <= hc_d;
      rv_q   <= acc & sel_read & ~sel_write;
      rid_q  <= gid;
      roor_q <= ~in_range;
      rd0_q  <= m0_readdata;
      rd1_q  <= m1_readdata;
      if (acc) begin
        addr_q <= sel_addr;
        be_q   <= sel_be;
        wd_q   <= sel_wd;
        if (!in_range && err_q != 8'd255) err_q <= err_q + 8'd1;
        if (sel_read && sel_write) proto_q <= 1'b1;
      end
    end
  end

endmodule
